ddr2_ctrl_rd_issue: RTL and testbench
=====================================

DDR2_CTRL_RD_ISSUE -- requirements
Module: ddr2_ctrl_rd_issue

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, meaning DDR2 local word-address width.
REQ-002 SHALL have parameter MAX_LEN, default 31, meaning the maximum command length in 128-bit words.
REQ-003 SHALL have port ddr2_clk, input, 1, the sole clock.
REQ-004 SHALL have port sys_rst_n, input, 1, reset (asynchronous, active-low).
REQ-005 SHALL have port cmd_valid, input, 1, read command present.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_addr, input, ADDR_W, start address in 32-bit local words.
REQ-008 SHALL have port cmd_len, input, 5, length in 128-bit words.
REQ-009 SHALL have port read_permit, input, 1, downstream output stage has size/valid FIFO room.
REQ-010 SHALL have port local_ready, input, 1, DDR2 controller accepts a request.
REQ-011 SHALL have port local_read_req, output, 1, read request to the DDR2 controller.
REQ-012 SHALL have port local_burstbegin, output, 1, first cycle of each request.
REQ-013 SHALL have port local_address, output, ADDR_W, burst address.
REQ-014 SHALL have port local_size, output, 3, burst length in beats; constant 3'd4.
REQ-015 SHALL have port rd_ddr2_size, output, 7, expected 32-bit beats (cmd_len*4).
REQ-016 SHALL have port rd_ddr2_size_wrreq, output, 1, one-cycle push of rd_ddr2_size downstream.
REQ-017 SHALL have port busy, output, 1, command in progress.

Function
REQ-018 SHALL use FSM states IDLE, WAIT_PERMIT, LOG_SIZE and ISSUE.
REQ-019 In IDLE, cmd_ready SHALL be high; on handshake the block SHALL latch addr and len, then go to WAIT_PERMIT.
REQ-020 A handshake with cmd_len==0 SHALL be consumed, SHALL NOT push a size, SHALL NOT issue bursts, and the FSM SHALL stay in IDLE.
REQ-021 A handshake with cmd_len>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-022 WAIT_PERMIT SHALL stay until read_permit is sampled high, then go to LOG_SIZE.
REQ-023 LOG_SIZE SHALL last exactly one cycle: rd_ddr2_size_wrreq=1, rd_ddr2_size={len,2'b00}; the next state is ISSUE.
REQ-024 The size push SHALL precede the first local_read_req by exactly 1 cycle.
REQ-025 ISSUE SHALL hold local_read_req=1 with stable local_address until local_ready is sampled high.
REQ-026 In ISSUE, local_burstbegin SHALL be high only in the first cycle of each burst request.
REQ-027 On each accepted burst, the address SHALL advance by 4 and the remaining-burst count SHALL decrement.
REQ-028 The address SHALL wrap modulo 2^ADDR_W with no error.
REQ-029 The last accepted burst SHALL return the FSM to IDLE, with cmd_ready high the next cycle.
REQ-030 Back-to-back commands SHALL have a minimum gap of 1 IDLE cycle.
REQ-031 A read_permit drop during ISSUE SHALL NOT stall the current command; the size is already logged.
REQ-032 busy SHALL be high in every state except IDLE.
REQ-033 cmd_ready SHALL be low in every state except IDLE.

Reset
REQ-034 On sys_rst_n low, the block SHALL immediately force: FSM to IDLE; local_read_req, local_burstbegin, rd_ddr2_size_wrreq and busy to 0; local_address and rd_ddr2_size to 0; cmd_ready to 1 after release.
REQ-035 Reset mid-ISSUE SHALL abandon the command with no further requests.

Configuration
REQ-036 With DDR2_RD_ISSUE_STATS_EN defined, the block SHALL add output stall_cnt[15:0], counting WAIT_PERMIT cycles.
REQ-037 stall_cnt SHALL saturate at 16'hFFFF and reset to 0.
REQ-038 Without DDR2_RD_ISSUE_STATS_EN, the port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-039 Shared package ddr2_ctrl_pkg SHALL hold the FSM state typedef, BEATS_PER_WORD=4 and LOCAL_BURST_SIZE=3'd4.
REQ-040 The block SHALL be a single module, with no sub-module.

Verification
REQ-041 Scenario: cmd addr=0x100, len=3, read_permit=1, local_ready=1 -> one rd_ddr2_size_wrreq with size 12; 3 requests at 0x100, 0x104, 0x108; cmd_ready high 5 cycles after acceptance.
REQ-042 Scenario: read_permit=0 for 10 cycles after accept -> no wrreq and no request during those cycles; stall_cnt=10 with the macro defined.
REQ-043 Scenario: local_ready low for 4 cycles on the 2nd burst -> address 0x104 held stable; local_burstbegin pulses exactly once per burst.
REQ-044 Scenario: cmd_len=0 -> accepted with no size push and no request; cmd_len=31 -> size 124 and 31 bursts.
REQ-045 Scenario: addr=2^25-4, len=2 -> bursts at 0x1FFFFFC then 0x0000000.
REQ-046 Scenario: reset asserted during the 2nd of 4 bursts -> outputs 0 immediately; after release, a new command runs normally.

Source files
------------

// File: rtl/ddr2_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ddr2_ctrl_pkg
//   Shared definitions for the DDR2 controller slice.
//   - rd_state_t        : read-issue FSM state encoding
//   - BEATS_PER_WORD    : 32-bit beats carried by one 128-bit word
//   - LOCAL_BURST_SIZE  : burst length (beats) presented on local_size
//   - BURST_ADDR_STEP   : local word-address advance per issued burst
//   - words_to_beats()  : 128-bit word count -> expected 32-bit beat count
// ----------------------------------------------------------------------------
package ddr2_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_PERMIT = 2'd1,
    LOG_SIZE    = 2'd2,
    ISSUE       = 2'd3
  } rd_state_t;

  localparam int unsigned BEATS_PER_WORD   = 4;
  localparam logic [2:0]  LOCAL_BURST_SIZE = 3'd4;

  // One burst moves one 128-bit word, i.e. four 32-bit local words.
  localparam int unsigned BURST_ADDR_STEP  = 4;

  // Beat count for a command of len 128-bit words; 31 words -> 124 beats fits 7 bits.
  function automatic logic [6:0] words_to_beats(input logic [4:0] len);
    return 7'(len) * 7'(BEATS_PER_WORD);
  endfunction

endpackage

// File: rtl/ddr2_ctrl_rd_issue.sv
// ----------------------------------------------------------------------------
// ddr2_ctrl_rd_issue
//   Turns a read command (start address + length in 128-bit words) into a
//   sequence of fixed-size DDR2 local read bursts. Before the first burst of a
//   command, the expected beat count is pushed once to the downstream output
//   stage, and only when that stage reports room (read_permit).
//
//   Optional build macro: DDR2_RD_ISSUE_STATS_EN adds the stall_cnt output.
//
// Ports
//   ddr2_clk            in   sole clock
//   sys_rst_n           in   asynchronous active-low reset
//   cmd_valid/cmd_ready in/out command handshake
//   cmd_addr            in   start address (32-bit local words)
//   cmd_len             in   length in 128-bit words (0 = no-op)
//   read_permit         in   downstream size/valid FIFO has room
//   local_ready         in   DDR2 controller accepts the current request
//   local_read_req      out  read request
//   local_burstbegin    out  first cycle of each burst request
//   local_address       out  burst address
//   local_size          out  burst length in beats (constant 4)
//   rd_ddr2_size        out  expected 32-bit beats for the command
//   rd_ddr2_size_wrreq  out  one-cycle push of rd_ddr2_size
//   busy                out  command in progress
//   stall_cnt           out  (DDR2_RD_ISSUE_STATS_EN only) saturating count of
//                            cycles spent waiting for read_permit
// ----------------------------------------------------------------------------
module ddr2_ctrl_rd_issue
  import ddr2_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 25,
  parameter int MAX_LEN = 31
) (
  input  logic              ddr2_clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [4:0]        cmd_len,
  input  logic              read_permit,
  input  logic              local_ready,
  output logic              local_read_req,
  output logic              local_burstbegin,
  output logic [ADDR_W-1:0] local_address,
  output logic [2:0]        local_size,
  output logic [6:0]        rd_ddr2_size,
  output logic              rd_ddr2_size_wrreq,
  output logic              busy
`ifdef DDR2_RD_ISSUE_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [4:0] MAX_LEN_C = 5'(MAX_LEN);

  rd_state_t         state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [4:0]        remain_r;
  logic              cmd_ready_r;
  logic              read_req_r;
  logic              burstbegin_r;
  logic [6:0]        size_r;
  logic              size_wrreq_r;
  logic              busy_r;

  logic [4:0]        len_clamped_s;
  logic [ADDR_W-1:0] addr_inc_s;

  // Clamp oversized command lengths to MAX_LEN.
  always_comb begin
    len_clamped_s = cmd_len;
    if (32'(cmd_len) > MAX_LEN) begin
      len_clamped_s = MAX_LEN_C;
    end else begin
      len_clamped_s = cmd_len;
    end
  end

  // Next burst address; natural truncation gives the modulo-2^ADDR_W wrap.
  always_comb begin
    addr_inc_s = addr_r + ADDR_W'(BURST_ADDR_STEP);
  end

  // Read-issue FSM; every output is a register updated with the state.
  always_ff @(posedge ddr2_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= IDLE;
      addr_r       <= '0;
      remain_r     <= 5'd0;
      cmd_ready_r  <= 1'b1;
      read_req_r   <= 1'b0;
      burstbegin_r <= 1'b0;
      size_r       <= 7'd0;
      size_wrreq_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      // Single-cycle pulses fall back to zero unless re-armed below.
      size_wrreq_r <= 1'b0;
      burstbegin_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            if (len_clamped_s == 5'd0) begin
              // Zero-length command: consumed, nothing issued, remain ready.
              state_r     <= IDLE;
              cmd_ready_r <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              state_r     <= WAIT_PERMIT;
              addr_r      <= cmd_addr;
              remain_r    <= len_clamped_s;
              cmd_ready_r <= 1'b0;
              busy_r      <= 1'b1;
            end
          end else begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end

        WAIT_PERMIT: begin
          if (read_permit) begin
            state_r      <= LOG_SIZE;
            size_r       <= words_to_beats(remain_r);
            size_wrreq_r <= 1'b1;
          end else begin
            state_r <= WAIT_PERMIT;
          end
        end

        LOG_SIZE: begin
          // Size was pushed this cycle; the first request follows next cycle.
          state_r      <= ISSUE;
          read_req_r   <= 1'b1;
          burstbegin_r <= 1'b1;
        end

        ISSUE: begin
          // read_permit is deliberately ignored here: the size is already logged.
          if (local_ready) begin
            addr_r   <= addr_inc_s;
            remain_r <= remain_r - 5'd1;
            if (remain_r == 5'd1) begin
              state_r     <= IDLE;
              read_req_r  <= 1'b0;
              cmd_ready_r <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              state_r      <= ISSUE;
              read_req_r   <= 1'b1;
              burstbegin_r <= 1'b1;
            end
          end else begin
            // Hold request and address until the controller takes it.
            state_r    <= ISSUE;
            read_req_r <= 1'b1;
          end
        end

        default: begin
          state_r     <= IDLE;
          read_req_r  <= 1'b0;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready          = cmd_ready_r;
  assign local_read_req     = read_req_r;
  assign local_burstbegin   = burstbegin_r;
  assign local_address      = addr_r;
  assign local_size         = LOCAL_BURST_SIZE;
  assign rd_ddr2_size       = size_r;
  assign rd_ddr2_size_wrreq = size_wrreq_r;
  assign busy               = busy_r;

`ifdef DDR2_RD_ISSUE_STATS_EN
  logic [15:0] stall_cnt_r;

  // Count cycles blocked on read_permit, saturating at all-ones.
  always_ff @(posedge ddr2_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == WAIT_PERMIT) && !read_permit && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_ddr2_ctrl_rd_issue.sv
// ----------------------------------------------------------------------------
// tb_ddr2_ctrl_rd_issue
//   Directed bench for ddr2_ctrl_rd_issue. A negedge monitor records size
//   pushes, requests, burst starts and accepted burst addresses; each test
//   task drives one scenario and compares against hand-computed values.
// ----------------------------------------------------------------------------
module tb_ddr2_ctrl_rd_issue;

  logic        ddr2_clk;
  logic        sys_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [24:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic        read_permit;
  logic        local_ready;
  logic        local_read_req;
  logic        local_burstbegin;
  logic [24:0] local_address;
  logic [2:0]  local_size;
  logic [6:0]  rd_ddr2_size;
  logic        rd_ddr2_size_wrreq;
  logic        busy;
`ifdef DDR2_RD_ISSUE_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  ddr2_ctrl_rd_issue #(.ADDR_W(25), .MAX_LEN(31)) dut (
    .ddr2_clk           (ddr2_clk),
    .sys_rst_n          (sys_rst_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_addr           (cmd_addr),
    .cmd_len            (cmd_len),
    .read_permit        (read_permit),
    .local_ready        (local_ready),
    .local_read_req     (local_read_req),
    .local_burstbegin   (local_burstbegin),
    .local_address      (local_address),
    .local_size         (local_size),
    .rd_ddr2_size       (rd_ddr2_size),
    .rd_ddr2_size_wrreq (rd_ddr2_size_wrreq),
    .busy               (busy)
`ifdef DDR2_RD_ISSUE_STATS_EN
    ,
    .stall_cnt          (stall_cnt)
`endif
  );

  initial ddr2_clk = 1'b0;
  always #5 ddr2_clk = ~ddr2_clk;

  // Monitor state
  int          cyc = 0;
  int          wr_cnt;
  int          wr_cyc;
  logic [6:0]  last_size;
  int          req_cnt;
  int          first_req_cyc;
  int          bb_cnt;
  int          unstable;
  logic        prev_req;
  logic        prev_acc;
  logic [24:0] prev_addr;
  logic [24:0] acc_q[$];
  int          acc_cyc_q[$];

  always @(posedge ddr2_clk) cyc <= cyc + 1;

  always @(negedge ddr2_clk) begin
    if (rd_ddr2_size_wrreq) begin
      wr_cnt    <= wr_cnt + 1;
      wr_cyc    <= cyc;
      last_size <= rd_ddr2_size;
    end
    if (local_read_req) begin
      req_cnt <= req_cnt + 1;
      if (first_req_cyc < 0) first_req_cyc <= cyc;
      if (prev_req && !prev_acc && (local_address !== prev_addr)) unstable <= unstable + 1;
    end
    if (local_burstbegin) bb_cnt <= bb_cnt + 1;
    if (local_read_req && local_ready) acc_q.push_back(local_address);
    if (cmd_valid && cmd_ready) acc_cyc_q.push_back(cyc);
    prev_req  <= local_read_req;
    prev_acc  <= local_read_req && local_ready;
    prev_addr <= local_address;
  end

  task automatic clear_log();
    wr_cnt = 0; wr_cyc = 0; last_size = 7'd0; req_cnt = 0;
    first_req_cyc = -1; bb_cnt = 0; unstable = 0;
    acc_q.delete(); acc_cyc_q.delete();
  endtask

  // Present one command; called #1 after a posedge while cmd_ready is high.
  task automatic send_cmd(input logic [24:0] addr, input logic [4:0] len);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len;
    @(posedge ddr2_clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Count edges until cmd_ready returns; an expired budget is a failure.
  task automatic wait_idle(output int n, input int budget);
    n = 0;
    do begin
      @(posedge ddr2_clk); #1;
      n++;
    end while (!cmd_ready && n < budget);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_idle_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 25'd0; cmd_len = 5'd0;
    read_permit = 1'b1; local_ready = 1'b1;
    clear_log();
    repeat (3) @(posedge ddr2_clk); #1;
    checks++; if (local_read_req !== 1'b0) begin failures++; $display("FAIL rst_read_req: got %b required 0", local_read_req); end
    checks++; if (local_burstbegin !== 1'b0) begin failures++; $display("FAIL rst_burstbegin: got %b required 0", local_burstbegin); end
    checks++; if (rd_ddr2_size_wrreq !== 1'b0) begin failures++; $display("FAIL rst_wrreq: got %b required 0", rd_ddr2_size_wrreq); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (local_address !== 25'd0) begin failures++; $display("FAIL rst_addr: got %h required 0", local_address); end
    checks++; if (rd_ddr2_size !== 7'd0) begin failures++; $display("FAIL rst_size: got %0d required 0", rd_ddr2_size); end
    checks++; if (local_size !== 3'd4) begin failures++; $display("FAIL local_size: got %0d required 4", local_size); end
    @(negedge ddr2_clk); sys_rst_n = 1'b1;
    @(posedge ddr2_clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
`ifdef DDR2_RD_ISSUE_STATS_EN
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rst_stall_cnt: got %0d required 0", stall_cnt); end
`endif
  endtask

  task automatic test_basic();
    int n;
    read_permit = 1'b1; local_ready = 1'b1;
    clear_log();
    send_cmd(25'h100, 5'd3);
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_accept: ready=%b busy=%b required 0/1", cmd_ready, busy); end
    wait_idle(n, 20);
    checks++; if (n != 5) begin failures++; $display("FAIL basic_latency: got %0d cycles required 5", n); end
    checks++; if (wr_cnt != 1) begin failures++; $display("FAIL basic_wr_cnt: got %0d required 1", wr_cnt); end
    checks++; if (last_size !== 7'd12) begin failures++; $display("FAIL basic_size: got %0d required 12", last_size); end
    checks++; if (first_req_cyc - wr_cyc != 1) begin failures++; $display("FAIL basic_size_lead: got %0d required 1", first_req_cyc - wr_cyc); end
    checks++; if (bb_cnt != 3) begin failures++; $display("FAIL basic_burstbegin: got %0d required 3", bb_cnt); end
    checks++;
    if (acc_q.size() != 3) begin failures++; $display("FAIL basic_bursts: got %0d required 3", acc_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_q[i] !== 25'(32'h100 + 32'(i) * 32'd4)) begin
          failures++; $display("FAIL basic_addr%0d: got %h required %h", i, acc_q[i], 32'h100 + 32'(i) * 32'd4);
        end
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_log();
    send_cmd(25'h500, 5'd1);
    wait_idle(n, 20);
    send_cmd(25'h600, 5'd1);
    wait_idle(n, 20);
    checks++;
    if (acc_cyc_q.size() != 2) begin failures++; $display("FAIL b2b_accepts: got %0d required 2", acc_cyc_q.size()); end
    else begin
      checks++;
      if (acc_cyc_q[1] - acc_cyc_q[0] != 4) begin failures++; $display("FAIL b2b_gap: got %0d required 4", acc_cyc_q[1] - acc_cyc_q[0]); end
    end
    checks++;
    if (acc_q.size() != 2) begin failures++; $display("FAIL b2b_bursts: got %0d required 2", acc_q.size()); end
    else begin
      checks++; if (acc_q[0] !== 25'h500) begin failures++; $display("FAIL b2b_addr0: got %h required 500", acc_q[0]); end
      checks++; if (acc_q[1] !== 25'h600) begin failures++; $display("FAIL b2b_addr1: got %h required 600", acc_q[1]); end
    end
  endtask

  task automatic test_permit_stall();
    int n;
`ifdef DDR2_RD_ISSUE_STATS_EN
    logic [15:0] stall_before;
    stall_before = stall_cnt;
`endif
    read_permit = 1'b0;
    clear_log();
    send_cmd(25'h200, 5'd2);
    repeat (10) @(posedge ddr2_clk); #1;
    checks++; if (wr_cnt != 0) begin failures++; $display("FAIL stall_wrreq: got %0d required 0", wr_cnt); end
    checks++; if (req_cnt != 0) begin failures++; $display("FAIL stall_req: got %0d required 0", req_cnt); end
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL stall_busy: busy=%b ready=%b required 1/0", busy, cmd_ready); end
`ifdef DDR2_RD_ISSUE_STATS_EN
    checks++; if (stall_cnt - stall_before !== 16'd10) begin failures++; $display("FAIL stall_cnt: got %0d required 10", stall_cnt - stall_before); end
`endif
    read_permit = 1'b1;
    wait_idle(n, 20);
    checks++; if (n != 4) begin failures++; $display("FAIL stall_latency: got %0d required 4", n); end
    checks++; if (wr_cnt != 1 || last_size !== 7'd8) begin failures++; $display("FAIL stall_size: cnt=%0d size=%0d required 1/8", wr_cnt, last_size); end
    checks++;
    if (acc_q.size() != 2) begin failures++; $display("FAIL stall_bursts: got %0d required 2", acc_q.size()); end
    else begin
      checks++; if (acc_q[1] !== 25'h204) begin failures++; $display("FAIL stall_addr1: got %h required 204", acc_q[1]); end
    end
  endtask

  task automatic test_permit_drop();
    int n;
    read_permit = 1'b1; local_ready = 1'b1;
    clear_log();
    send_cmd(25'h240, 5'd4);
    repeat (2) @(posedge ddr2_clk); #1;
    read_permit = 1'b0;
    wait_idle(n, 20);
    checks++; if (n != 4) begin failures++; $display("FAIL drop_latency: got %0d required 4", n); end
    checks++; if (acc_q.size() != 4) begin failures++; $display("FAIL drop_bursts: got %0d required 4", acc_q.size()); end
    checks++; if (wr_cnt != 1) begin failures++; $display("FAIL drop_wr_cnt: got %0d required 1", wr_cnt); end
    read_permit = 1'b1;
  endtask

  task automatic test_ready_stall();
    int n;
    clear_log();
    send_cmd(25'h100, 5'd3);
    repeat (3) @(posedge ddr2_clk); #1;
    local_ready = 1'b0;
    checks++; if (local_burstbegin !== 1'b1 || local_address !== 25'h104) begin failures++; $display("FAIL rdy_2nd_start: bb=%b addr=%h required 1/104", local_burstbegin, local_address); end
    repeat (4) @(posedge ddr2_clk); #1;
    checks++; if (local_address !== 25'h104) begin failures++; $display("FAIL rdy_hold_addr: got %h required 104", local_address); end
    checks++; if (local_read_req !== 1'b1 || local_burstbegin !== 1'b0) begin failures++; $display("FAIL rdy_hold_req: req=%b bb=%b required 1/0", local_read_req, local_burstbegin); end
    local_ready = 1'b1;
    wait_idle(n, 20);
    checks++; if (n != 2) begin failures++; $display("FAIL rdy_latency: got %0d required 2", n); end
    checks++; if (bb_cnt != 3) begin failures++; $display("FAIL rdy_burstbegin: got %0d required 3", bb_cnt); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL rdy_addr_stable: got %0d changes required 0", unstable); end
    checks++;
    if (acc_q.size() != 3) begin failures++; $display("FAIL rdy_bursts: got %0d required 3", acc_q.size()); end
    else begin
      checks++; if (acc_q[2] !== 25'h108) begin failures++; $display("FAIL rdy_addr2: got %h required 108", acc_q[2]); end
    end
  endtask

  task automatic test_len_edges();
    int n;
    clear_log();
    send_cmd(25'h700, 5'd0);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL len0_idle: ready=%b busy=%b required 1/0", cmd_ready, busy); end
    repeat (5) @(posedge ddr2_clk); #1;
    checks++; if (wr_cnt != 0 || req_cnt != 0) begin failures++; $display("FAIL len0_activity: wr=%0d req=%0d required 0/0", wr_cnt, req_cnt); end
    checks++; if (acc_cyc_q.size() != 1) begin failures++; $display("FAIL len0_consumed: got %0d required 1", acc_cyc_q.size()); end
    clear_log();
    send_cmd(25'h0, 5'd31);
    wait_idle(n, 60);
    checks++; if (n != 33) begin failures++; $display("FAIL len31_latency: got %0d required 33", n); end
    checks++; if (last_size !== 7'd124) begin failures++; $display("FAIL len31_size: got %0d required 124", last_size); end
    checks++; if (bb_cnt != 31) begin failures++; $display("FAIL len31_burstbegin: got %0d required 31", bb_cnt); end
    checks++;
    if (acc_q.size() != 31) begin failures++; $display("FAIL len31_bursts: got %0d required 31", acc_q.size()); end
    else begin
      for (int i = 0; i < 31; i++) begin
        checks++;
        if (acc_q[i] !== 25'(i * 4)) begin failures++; $display("FAIL len31_addr%0d: got %h required %h", i, acc_q[i], i * 4); end
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    clear_log();
    send_cmd(25'h1FFFFFC, 5'd2);
    wait_idle(n, 20);
    checks++;
    if (acc_q.size() != 2) begin failures++; $display("FAIL wrap_bursts: got %0d required 2", acc_q.size()); end
    else begin
      checks++; if (acc_q[0] !== 25'h1FFFFFC) begin failures++; $display("FAIL wrap_addr0: got %h required 1fffffc", acc_q[0]); end
      checks++; if (acc_q[1] !== 25'h0) begin failures++; $display("FAIL wrap_addr1: got %h required 0", acc_q[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int req_before;
    clear_log();
    send_cmd(25'h300, 5'd4);
    repeat (3) @(posedge ddr2_clk); #1;
    checks++; if (local_address !== 25'h304 || local_read_req !== 1'b1) begin failures++; $display("FAIL rmid_pre: addr=%h req=%b required 304/1", local_address, local_read_req); end
    sys_rst_n = 1'b0;
    #1;
    checks++; if (local_read_req !== 1'b0 || local_burstbegin !== 1'b0 || rd_ddr2_size_wrreq !== 1'b0) begin failures++; $display("FAIL rmid_outs: req=%b bb=%b wr=%b required 0", local_read_req, local_burstbegin, rd_ddr2_size_wrreq); end
    checks++; if (busy !== 1'b0 || local_address !== 25'd0 || rd_ddr2_size !== 7'd0) begin failures++; $display("FAIL rmid_state: busy=%b addr=%h size=%0d required 0", busy, local_address, rd_ddr2_size); end
    req_before = req_cnt;
    repeat (3) @(posedge ddr2_clk);
    @(negedge ddr2_clk); sys_rst_n = 1'b1;
    repeat (3) @(posedge ddr2_clk); #1;
    checks++; if (req_cnt != req_before) begin failures++; $display("FAIL rmid_no_req: got %0d required %0d", req_cnt, req_before); end
    checks++; if (acc_q.size() != 1) begin failures++; $display("FAIL rmid_bursts: got %0d required 1", acc_q.size()); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b required 1", cmd_ready); end
    clear_log();
    send_cmd(25'h400, 5'd2);
    wait_idle(n, 20);
    checks++; if (n != 4) begin failures++; $display("FAIL rmid_new_latency: got %0d required 4", n); end
    checks++; if (wr_cnt != 1 || last_size !== 7'd8) begin failures++; $display("FAIL rmid_new_size: cnt=%0d size=%0d required 1/8", wr_cnt, last_size); end
    checks++;
    if (acc_q.size() != 2) begin failures++; $display("FAIL rmid_new_bursts: got %0d required 2", acc_q.size()); end
    else begin
      checks++; if (acc_q[0] !== 25'h400 || acc_q[1] !== 25'h404) begin failures++; $display("FAIL rmid_new_addr: got %h,%h required 400,404", acc_q[0], acc_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_permit_stall();
    test_permit_drop();
    test_ready_stall();
    test_len_edges();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
